// File: rtl/sparc_mem_responder.sv
// Byte-addressed big-endian RAM responder that closes the MOV/MOC memory handshake.
// Latency: MOC rises LATENCY+1 edges after the edge that captures MOV; all outputs registered.
// Backpressure: 4-phase; MOC holds while MOV is high, and MOV low for one edge returns to idle.
module sparc_mem_responder #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        MOV,
  input  logic        R_W,
  input  logic [1:0]  Type,
  input  logic        Signed,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        AlignErr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  // Request fields latched at capture; later input changes are ignored.
  logic [31:0] a_q;
  logic [31:0] d_q;
  logic [1:0]  t_q;
  logic        rw_q;
  logic        sg_q;

  logic [7:0] mem [DEPTH];

  logic [2:0]    size;
  logic [32:0]   end_addr;
  logic          err;
  logic          access;
  logic [AW-1:0] ai;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   rdata;

  // Decode access size, legality and the big-endian read value of the captured request.
  always_comb begin
    size = 3'd4;
    case (t_q)
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      default: size = 3'd4;
    endcase
    // 33-bit sum so addresses near 2^32 cannot wrap into range.
    end_addr = {1'b0, a_q} + {30'd0, size};
    err = (t_q == 2'b11) ||
          (t_q == 2'b01 && a_q[0]) ||
          (t_q == 2'b10 && a_q[1:0] != 2'b00) ||
          (end_addr > 33'(DEPTH));
    access = (state == BUSY) && MOV && (cnt == '0);
    ai = a_q[AW-1:0];
    b0 = mem[ai];
    b1 = mem[ai + AW'(1)];
    b2 = mem[ai + AW'(2)];
    b3 = mem[ai + AW'(3)];
    rdata = {b0, b1, b2, b3};
    case (t_q)
      2'b00:   rdata = sg_q ? {{24{b0[7]}}, b0} : {24'd0, b0};
      2'b01:   rdata = sg_q ? {{16{b0[7]}}, b0, b1} : {16'd0, b0, b1};
      default: rdata = {b0, b1, b2, b3};
    endcase
  end

  // RAM store in the access cycle; RAM is never cleared and reset suppresses the write.
  always_ff @(posedge Clk) begin
    if (Clr && access && !err && !rw_q) begin
      case (t_q)
        2'b00: mem[ai] <= d_q[7:0];
        2'b01: begin
          mem[ai]         <= d_q[15:8];
          mem[ai + AW'(1)] <= d_q[7:0];
        end
        default: begin
          mem[ai]         <= d_q[31:24];
          mem[ai + AW'(1)] <= d_q[23:16];
          mem[ai + AW'(2)] <= d_q[15:8];
          mem[ai + AW'(3)] <= d_q[7:0];
        end
      endcase
    end
  end

  // Handshake FSM: capture in IDLE, count down in BUSY, hold the response in DONE.
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      state    <= IDLE;
      cnt      <= '0;
      MOC      <= 1'b0;
      AlignErr <= 1'b0;
      DataOut  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MOV) begin
            a_q   <= Address;
            d_q   <= DataIn;
            t_q   <= Type;
            rw_q  <= R_W;
            sg_q  <= Signed;
            cnt   <= CW'(LATENCY);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!MOV) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state <= DONE;
            MOC   <= 1'b1;
            if (err) begin
              AlignErr <= 1'b1;
              DataOut  <= '0;
            end else if (rw_q) begin
              DataOut <= rdata;
            end
          end
        end
        DONE: begin
          if (!MOV) begin
            state    <= IDLE;
            MOC      <= 1'b0;
            AlignErr <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sparc_mem_responder.sv
// Randomized bench for sparc_mem_responder against a byte-array reference memory.
// Latency: checks MOC timing for LATENCY=2 (main) and LATENCY=0 (second instance).
// Backpressure: drives the 4-phase MOV/MOC handshake, including aborts and resets.
module tb_sparc_mem_responder;

  logic        Clk = 1'b0;
  logic        Clr = 1'b0;
  logic        MOV = 1'b0;
  logic        mov0 = 1'b0;
  logic        R_W = 1'b0;
  logic [1:0]  Type = 2'b00;
  logic        Signed = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] DataIn = '0;
  logic [31:0] DataOut, dout0;
  logic        MOC, moc0, AlignErr, err0;

  bit use0 = 1'b0;
  wire        cur_moc  = use0 ? moc0  : MOC;
  wire        cur_err  = use0 ? err0  : AlignErr;
  wire [31:0] cur_dout = use0 ? dout0 : DataOut;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ref_mem [512];
  logic [31:0] last_d = '0;

  sparc_mem_responder #(.DEPTH(512), .LATENCY(2)) dut (
    .Clk(Clk), .Clr(Clr), .MOV(MOV), .R_W(R_W), .Type(Type), .Signed(Signed),
    .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MOC(MOC), .AlignErr(AlignErr)
  );

  sparc_mem_responder #(.DEPTH(512), .LATENCY(0)) dut0 (
    .Clk(Clk), .Clr(Clr), .MOV(mov0), .R_W(R_W), .Type(Type), .Signed(Signed),
    .Address(Address), .DataIn(DataIn), .DataOut(dout0), .MOC(moc0), .AlignErr(err0)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: access size, legality and big-endian value straight from the rules.
  task automatic model(input bit rw, input logic [1:0] typ, input bit sg,
                       input logic [31:0] addr, input logic [31:0] din,
                       output logic [31:0] exp_d, output bit exp_e);
    int     size;
    longint val;
    size  = (typ == 2'd0) ? 1 : (typ == 2'd1) ? 2 : 4;
    exp_e = (typ == 2'd3) || ((addr % size) != 0) ||
            (longint'({32'd0, addr}) + size > 512);
    if (exp_e) begin
      last_d = '0;
    end else if (rw) begin
      val = 0;
      for (int i = 0; i < size; i++) val = val * 256 + ref_mem[addr + i];
      if (sg && size < 4 && val >= (longint'(1) << (8 * size - 1)))
        val = val - (longint'(1) << (8 * size));
      last_d = val[31:0];
    end else begin
      for (int i = 0; i < size; i++)
        ref_mem[addr + i] = 8'((din >> (8 * (size - 1 - i))) & 32'hFF);
    end
    exp_d = last_d;
  endtask

  // One full handshake on the selected instance with timing, response and release checks.
  task automatic do_op(input bit sel, input bit rw, input logic [1:0] typ, input bit sg,
                       input logic [31:0] addr, input logic [31:0] din, input int hold,
                       input int exp_lat, input logic [31:0] exp_d, input bit exp_e);
    int lat;
    use0 = sel;
    @(negedge Clk);
    R_W = rw; Type = typ; Signed = sg; Address = addr; DataIn = din;
    if (sel) mov0 = 1'b1; else MOV = 1'b1;
    @(posedge Clk); #1;
    Address = $urandom; DataIn = $urandom; Type = 2'($urandom); R_W = 1'($urandom);
    lat = 0;
    while (!cur_moc && lat < 20) begin
      @(posedge Clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("moc", cur_moc, 1);
    chk("alignerr", cur_err, exp_e);
    chk("dataout", cur_dout, exp_d);
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk); #1;
      chk("moc_hold", cur_moc, 1);
      chk("dout_hold", cur_dout, exp_d);
    end
    @(negedge Clk);
    if (sel) mov0 = 1'b0; else MOV = 1'b0;
    @(posedge Clk); #1;
    chk("moc_clr", cur_moc, 0);
    chk("err_clr", cur_err, 0);
    chk("dout_keep", cur_dout, exp_d);
  endtask

  task automatic txn(input bit rw, input logic [1:0] typ, input bit sg,
                     input logic [31:0] addr, input logic [31:0] din, input int hold);
    logic [31:0] exp_d;
    bit          exp_e;
    model(rw, typ, sg, addr, din, exp_d, exp_e);
    do_op(1'b0, rw, typ, sg, addr, din, hold, 3, exp_d, exp_e);
  endtask

  // Start a write, keep MOV for the capture edge plus one, then withdraw or reset.
  task automatic start_write(input logic [31:0] addr, input logic [31:0] din);
    use0 = 1'b0;
    @(negedge Clk);
    R_W = 1'b0; Type = 2'd2; Signed = 1'b0; Address = addr; DataIn = din; MOV = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_moc", MOC, 0);
    chk("rst_err", AlignErr, 0);
    chk("rst_dout", DataOut, 0);
    chk("rst_moc0", moc0, 0);
    @(negedge Clk);
    Clr = 1'b1;

    // Fill RAM so the reference model is fully known
    for (int a = 0; a < 512; a += 4) txn(1'b0, 2'd2, 1'b0, 32'(a), $urandom, 0);

    // Word write/read, byte reads, byte store, signed/unsigned loads
    txn(1'b0, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 0);
    txn(1'b1, 2'd2, 1'b0, 32'h010, 32'h0, 0);
    for (int a = 16; a < 20; a++) txn(1'b1, 2'd0, 1'b0, 32'(a), 32'h0, 0);
    txn(1'b0, 2'd0, 1'b0, 32'h011, 32'hFFFFFF80, 0);
    txn(1'b1, 2'd2, 1'b0, 32'h010, 32'h0, 0);
    txn(1'b1, 2'd0, 1'b1, 32'h011, 32'h0, 0);
    txn(1'b1, 2'd0, 1'b0, 32'h011, 32'h0, 0);
    txn(1'b1, 2'd1, 1'b1, 32'h012, 32'h0, 0);
    txn(1'b0, 2'd1, 1'b0, 32'h013, 32'h5555, 0);
    txn(1'b1, 2'd2, 1'b0, 32'h010, 32'h0, 0);

    // Range and reserved-size errors
    txn(1'b0, 2'd2, 1'b0, 32'h1FC, 32'hA5A55A5A, 0);
    txn(1'b1, 2'd2, 1'b0, 32'h1FC, 32'h0, 0);
    txn(1'b0, 2'd2, 1'b0, 32'h1FE, 32'h11111111, 0);
    txn(1'b0, 2'd2, 1'b0, 32'h200, 32'h22222222, 0);
    txn(1'b0, 2'd3, 1'b0, 32'h020, 32'h33333333, 0);
    txn(1'b1, 2'd2, 1'b0, 32'h020, 32'h0, 0);
    txn(1'b1, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0, 0);

    // Abort during BUSY: no MOC, no write
    start_write(32'h020, 32'h12345678);
    @(negedge Clk);
    MOV = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      chk("abort_moc", MOC, 0);
    end
    txn(1'b1, 2'd2, 1'b0, 32'h020, 32'h0, 0);

    // Holding MOV in DONE
    txn(1'b1, 2'd2, 1'b0, 32'h010, 32'h0, 5);

    // Reset mid-operation
    start_write(32'h024, 32'h12345678);
    @(negedge Clk);
    Clr = 1'b0;
    @(posedge Clk); #1;
    chk("rst_mid_moc", MOC, 0);
    chk("rst_mid_dout", DataOut, 0);
    @(negedge Clk);
    Clr = 1'b1;
    MOV = 1'b0;
    last_d = '0;
    txn(1'b1, 2'd2, 1'b0, 32'h024, 32'h0, 0);

    // LATENCY=0 instance
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h040, 32'hCAFEF00D, 0, 1, 32'h0, 1'b0);
    do_op(1'b1, 1'b1, 2'd2, 1'b0, 32'h040, 32'h0, 0, 1, 32'hCAFEF00D, 1'b0);
    use0 = 1'b0;

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 511)) : 32'($urandom_range(500, 530));
      txn(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
